// File: rtl/i2s_pkg.sv
// ============================================================================
// Package  : i2s_pkg
// Brief    : Shared widths, frame geometry and types for the I2S transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2s_pkg;

    localparam int I2S_SAMPLE_W   = 16;
    localparam int I2S_FRAME_BITS = 32;
    localparam int I2S_IDX_W      = 5;

    // LRCLK is high for these bit indices: it leads each word's MSB by one BCLK
    localparam logic [I2S_IDX_W-1:0] I2S_LR_FIRST = 5'd15;
    localparam logic [I2S_IDX_W-1:0] I2S_LR_LAST  = 5'd30;

    typedef logic [I2S_SAMPLE_W-1:0] i2s_sample_t;

    typedef struct packed {
        i2s_sample_t left;
        i2s_sample_t right;
    } i2s_pair_t;

    function automatic logic i2s_lr_window(input logic [I2S_IDX_W-1:0] idx);
        return (idx >= I2S_LR_FIRST) && (idx <= I2S_LR_LAST);
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_tx_if.sv
// ============================================================================
// Interface : i2s_tx_if
// Brief     : CPU-side sample handshake and control of the I2S transmitter.
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2s_tx_if;
    import i2s_pkg::*;

    logic        i_en;
    logic        i_valid;
    i2s_sample_t i_left;
    i2s_sample_t i_right;
    logic        o_ready;
    logic        i_clr_underrun;
    logic        o_underrun;

    modport master (
        output i_en,
        output i_valid,
        output i_left,
        output i_right,
        output i_clr_underrun,
        input  o_ready,
        input  o_underrun
    );

    modport slave (
        input  i_en,
        input  i_valid,
        input  i_left,
        input  i_right,
        input  i_clr_underrun,
        output o_ready,
        output o_underrun
    );

endinterface

`default_nettype wire

// File: rtl/i2s_bclk_gen.sv
// ============================================================================
// Module   : i2s_bclk_gen
// Brief    : Divides i_clk down to BCLK and flags the cycle before each edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_bclk_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    output logic o_bclk,
    output logic o_fall_stb,
    output logic o_rise_stb
);

    localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);

    if ((CLK_DIV < 1) || (CLK_DIV > 255)) begin : g_bad_div
        $error("i2s_bclk_gen: CLK_DIV must be in 1..255");
    end

    logic [7:0] div_cnt_q, div_cnt_d;
    logic       bclk_q, bclk_d;
    logic       w_term;

    assign w_term = i_en && (div_cnt_q == c_div_last);

    always_comb begin
        div_cnt_d = div_cnt_q + 8'd1;
        bclk_d    = bclk_q;
        if (!i_en) begin
            div_cnt_d = 8'd0;
            bclk_d    = 1'b0;
        end else if (w_term) begin
            div_cnt_d = 8'd0;
            bclk_d    = ~bclk_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_cnt_q <= 8'd0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    // Strobes are high in the cycle whose closing edge toggles BCLK
    assign o_bclk     = bclk_q;
    assign o_fall_stb = w_term && bclk_q;
    assign o_rise_stb = w_term && !bclk_q;

endmodule

`default_nettype wire

// File: rtl/i2s_tx.sv
// ============================================================================
// Module   : i2s_tx
// Brief    : I2S stereo transmitter with a one-frame holding register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_tx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 8
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    i2s_tx_if.slave  bus,
    output logic     o_bclk,
    output logic     o_lrclk,
    output logic     o_sdin
);

    logic w_fall;
    logic w_rise;

    i2s_bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_en       (bus.i_en),
        .o_bclk     (o_bclk),
        .o_fall_stb (w_fall),
        .o_rise_stb (w_rise)
    );

    i2s_pair_t                   hold_q, hold_d;
    logic                        hold_full_q, hold_full_d;
    logic [I2S_FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [I2S_IDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic                        lrclk_q, lrclk_d;
    logic                        sdin_q, sdin_d;
    logic                        underrun_q, underrun_d;

    logic                        w_accept;
    logic                        w_load;
    logic [I2S_IDX_W-1:0]        w_bit_next;
    logic [I2S_FRAME_BITS-1:0]   w_shreg_next;

    assign w_accept     = bus.i_valid && !hold_full_q;
    assign w_load       = w_fall && (bit_idx_q == 5'd31);
    assign w_bit_next   = bit_idx_q + 5'd1;
    assign w_shreg_next = w_load ? (hold_full_q ? hold_q : '0) : shreg_q;

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        lrclk_d     = lrclk_q;
        sdin_d      = sdin_q;
        underrun_d  = underrun_q;

        if (w_accept) begin
            hold_d      = '{left: bus.i_left, right: bus.i_right};
            hold_full_d = 1'b1;
        end else if (w_load) begin
            hold_full_d = 1'b0;
        end

        // A missed frame outranks a same-cycle clear so no underrun goes unseen
        if (w_load && !hold_full_q) begin
            underrun_d = 1'b1;
        end else if (bus.i_clr_underrun) begin
            underrun_d = 1'b0;
        end

        if (!bus.i_en) begin
            bit_idx_d = 5'd31;
            lrclk_d   = 1'b0;
            sdin_d    = 1'b0;
        end else if (w_fall) begin
            bit_idx_d = w_bit_next;
            shreg_d   = w_shreg_next;
            lrclk_d   = i2s_lr_window(w_bit_next);
            sdin_d    = w_shreg_next[5'd31 - w_bit_next];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shreg_q     <= '0;
            bit_idx_q   <= 5'd31;
            lrclk_q     <= 1'b0;
            sdin_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            lrclk_q     <= lrclk_d;
            sdin_q      <= sdin_d;
            underrun_q  <= underrun_d;
        end
    end

    assign o_lrclk        = lrclk_q;
    assign o_sdin         = sdin_q;
    assign bus.o_ready    = !hold_full_q;
    assign bus.o_underrun = underrun_q;

    a_strobes_exclusive : assert property (
        @(posedge i_clk) disable iff (!i_rst_n) !(w_rise && w_fall)
    );

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx.sv
// ============================================================================
// Module   : tb_i2s_tx
// Brief    : Self-checking bench: lane 0 runs CLK_DIV=2, lane 1 runs CLK_DIV=1.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2s_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #20 clk = ~clk;

    logic [1:0]  en_v, valid_v, clr_v;
    logic [15:0] left_v  [2];
    logic [15:0] right_v [2];
    logic [1:0]  bclk_v, lr_v, sdin_v, ready_v, und_v;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam int LANE_DIV = (gi == 0) ? 2 : 1;

        i2s_tx_if u_if ();
        assign u_if.i_en           = en_v[gi];
        assign u_if.i_valid        = valid_v[gi];
        assign u_if.i_left         = left_v[gi];
        assign u_if.i_right        = right_v[gi];
        assign u_if.i_clr_underrun = clr_v[gi];
        assign ready_v[gi]         = u_if.o_ready;
        assign und_v[gi]           = u_if.o_underrun;

        i2s_tx #(
            .CLK_DIV (LANE_DIV)
        ) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .bus     (u_if.slave),
            .o_bclk  (bclk_v[gi]),
            .o_lrclk (lr_v[gi]),
            .o_sdin  (sdin_v[gi])
        );

        // Model: time since enable decides BCLK; every 2*DIV ticks is one bit slot
        int          tick, nfall, b;
        logic        m_hold_v, m_bclk, m_lr, m_sdin, m_und, acc, setu;
        logic [31:0] m_hold, m_frame;

        initial forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                tick = 0; nfall = 0; m_hold_v = 0; m_hold = 0; m_frame = 0;
                m_bclk = 0; m_lr = 0; m_sdin = 0; m_und = 0;
            end else begin
                acc  = valid_v[gi] && !m_hold_v;
                setu = 0;
                if (!en_v[gi]) begin
                    tick = 0; nfall = 0; m_bclk = 0; m_lr = 0; m_sdin = 0;
                end else begin
                    tick++;
                    m_bclk = ((tick / LANE_DIV) % 2) == 1;
                    if (tick % (2 * LANE_DIV) == 0) begin
                        b = nfall % 32;
                        nfall++;
                        if (b == 0) begin
                            if (m_hold_v) begin
                                m_frame  = m_hold;
                                m_hold_v = 0;
                            end else begin
                                m_frame = 0;
                                m_und   = 1;
                                setu    = 1;
                            end
                        end
                        m_lr   = (b >= 15) && (b <= 30);
                        m_sdin = m_frame[31 - b];
                    end
                end
                if (clr_v[gi] && !setu) m_und = 0;
                if (acc) begin
                    m_hold_v = 1;
                    m_hold   = {left_v[gi], right_v[gi]};
                end
            end
        end

        initial forever begin
            @(negedge clk);
            chk($sformatf("lane%0d bclk", gi),     32'(bclk_v[gi]),  32'(m_bclk));
            chk($sformatf("lane%0d lrclk", gi),    32'(lr_v[gi]),    32'(m_lr));
            chk($sformatf("lane%0d sdin", gi),     32'(sdin_v[gi]),  32'(m_sdin));
            chk($sformatf("lane%0d ready", gi),    32'(ready_v[gi]), 32'(!m_hold_v));
            chk($sformatf("lane%0d underrun", gi), 32'(und_v[gi]),   32'(m_und));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic first_fall(input int ln, output int at);
        logic prev;
        int   guard;
        at = -1; guard = 0; prev = bclk_v[ln];
        while (at < 0 && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (!bclk_v[ln] && prev) at = cyc;
            prev = bclk_v[ln];
        end
    endtask

    // Collects SDIN/LRCLK as seen at the next 32 BCLK rises, first bit in MSB
    task automatic capture(input int ln, output logic [31:0] sd, output logic [31:0] lr);
        logic prev;
        int   got, guard;
        sd = '0; lr = '0; got = 0; guard = 0; prev = bclk_v[ln];
        while (got < 32 && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (bclk_v[ln] && !prev) begin
                sd = {sd[30:0], sdin_v[ln]};
                lr = {lr[30:0], lr_v[ln]};
                got++;
            end
            prev = bclk_v[ln];
        end
        if (got < 32) begin
            n_checks++;
            n_fail++;
            $display("FAIL capture lane%0d: got %0d rises required 32", ln, got);
        end
    endtask

    logic [31:0] b2b_exp [4];
    logic [31:0] b2b_got [4];

    initial begin
        logic [31:0] sd, lr;
        int          at;

        en_v = 0; valid_v = 0; clr_v = 0;
        for (int i = 0; i < 2; i++) begin
            left_v[i] = 0; right_v[i] = 0;
        end
        b2b_exp[0] = 32'h1234_5678; b2b_exp[1] = 32'h9ABC_DEF0;
        b2b_exp[2] = 32'hFFFF_0000; b2b_exp[3] = 32'h0001_8000;

        step(3);
        chk("reset bclk",     32'(bclk_v),  32'h0);
        chk("reset lrclk",    32'(lr_v),    32'h0);
        chk("reset sdin",     32'(sdin_v),  32'h0);
        chk("reset ready",    32'(ready_v), 32'h3);
        chk("reset underrun", 32'(und_v),   32'h0);

        // Single frame on lane 0, pair offered as reset releases
        en_v[0] = 1; valid_v[0] = 1; left_v[0] = 16'hA5F0; right_v[0] = 16'h0F0F;
        rst_n = 1;
        step(1);
        valid_v[0] = 0;
        chk("ready low after accept", 32'(ready_v[0]), 32'h0);
        first_fall(0, at);
        chk("first fall cycle", 32'(at), 32'd4);
        capture(0, sd, lr);
        chk("frame0 sdin", sd, 32'hA5F0_0F0F);
        chk("frame0 lrclk", lr, 32'h0001_FFFE);

        // Underrun on frame 1 (load edge 4 + 128)
        chk("no underrun yet", 32'(und_v[0]), 32'h0);
        step(1);
        chk("no underrun before load", 32'(und_v[0]), 32'h0);
        step(1);
        chk("underrun at frame1 load", 32'(und_v[0]), 32'h1);
        capture(0, sd, lr);
        chk("frame1 zeros", sd, 32'h0);
        chk("underrun sticky", 32'(und_v[0]), 32'h1);

        // Clear collides with the frame-2 underrun load at edge 260
        wait_cyc(259);
        clr_v[0] = 1;
        step(1);
        clr_v[0] = 0;
        chk("set beats clear", 32'(und_v[0]), 32'h1);
        wait_cyc(269);
        clr_v[0] = 1;
        step(1);
        clr_v[0] = 0;
        chk("clear underrun", 32'(und_v[0]), 32'h0);
        wait_cyc(300);
        chk("cleared stays", 32'(und_v[0]), 32'h0);
        wait_cyc(388);
        chk("underrun frame3", 32'(und_v[0]), 32'h1);

        // Mid-frame disable: bit 9 of frame 3 is sent from edge 424
        wait_cyc(394);
        valid_v[0] = 1; left_v[0] = 16'h8001; right_v[0] = 16'h7FFE;
        step(1);
        valid_v[0] = 0;
        chk("held pair ready", 32'(ready_v[0]), 32'h0);
        wait_cyc(425);
        en_v[0] = 0;
        step(1);
        chk("disable bclk",  32'(bclk_v[0]), 32'h0);
        chk("disable lrclk", 32'(lr_v[0]),   32'h0);
        chk("disable sdin",  32'(sdin_v[0]), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("disable ready held", 32'(ready_v[0]), 32'h0);
            step(1);
        end
        en_v[0] = 1;
        first_fall(0, at);
        chk("re-enable fall cycle", 32'(at), 32'd434);
        chk("ready after reload", 32'(ready_v[0]), 32'h1);
        capture(0, sd, lr);
        chk("reload sdin", sd, 32'h8001_7FFE);
        chk("reload lrclk", lr, 32'h0001_FFFE);

        // Asynchronous reset between clock edges
        step(10);
        @(posedge clk);
        #7 rst_n = 0;
        #1;
        chk("async bclk",     32'(bclk_v[0]),  32'h0);
        chk("async lrclk",    32'(lr_v[0]),    32'h0);
        chk("async sdin",     32'(sdin_v[0]),  32'h0);
        chk("async ready",    32'(ready_v[0]), 32'h1);
        chk("async underrun", 32'(und_v[0]),   32'h0);
        @(negedge clk);
        rst_n = 1;
        first_fall(0, at);
        chk("post-reset fall cycle", 32'(at), 32'd4);

        // Back-to-back on lane 1 (CLK_DIV=1)
        @(negedge clk);
        en_v[1] = 1; valid_v[1] = 1;
        left_v[1] = b2b_exp[0][31:16]; right_v[1] = b2b_exp[0][15:0];
        step(1);
        valid_v[1] = 0;
        step(1);
        fork
            begin
                for (int f = 0; f < 4; f++) capture(1, b2b_got[f], lr);
            end
            begin
                for (int p = 1; p < 4; p++) begin
                    int guard;
                    guard = 0;
                    while (!ready_v[1] && guard < 200) begin
                        step(1);
                        guard++;
                    end
                    valid_v[1] = 1;
                    left_v[1] = b2b_exp[p][31:16]; right_v[1] = b2b_exp[p][15:0];
                    step(1);
                    valid_v[1] = 0;
                end
            end
        join
        chk("b2b no underrun", 32'(und_v[1]), 32'h0);
        for (int f = 0; f < 4; f++) chk($sformatf("b2b frame%0d", f), b2b_got[f], b2b_exp[f]);

        step(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
